nabp_processing_scan_control: RTL and testbench
===============================================

Name: nabp_processing_scan_control

Overview:
- Sequencer for the processing-swappable datapath.
- For one projection angle it walks every line iteration of a partition. Within each line it steps the scan iterator across the image, up or down, while gating PE updates with the filtered-RAM valid flag.
- Sits between the host angle scheduler (tt_*), the filtered-RAM front end (pv_*) and the PE array (pe_*).

Parameters:
- kAngleLength, 9, angle width in integer degrees; legal range 0..179.
- kImageSize, 8, pixels per scan line; scan_max = kImageSize-1.
- kPartitionSize, 4, line iterations per angle.
- kPartitionSizeLength, 3, width of line iterator: ceil(log2(kPartitionSize+1)).
- kScanLength, 4, width of scan iterator: ceil(log2(kImageSize+1)).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tt_angle  in  kAngleLength  angle; sampled with tt_kick.
- tt_kick  in  1  start request; accepted only when tt_ready=1.
- tt_ready  out  1  controller idle, can accept kick.
- tt_done  out  1  one-cycle pulse when angle fully processed.
- tt_err  out  1  one-cycle pulse when kicked with angle >= 180.
- pv_valid  in  1  filtered RAM data valid this cycle; low = stall.
- pe_angle  out  kAngleLength  latched angle.
- pe_scan_mode  out  1  0 = x-scan, 1 = y-scan.
- pe_scan_dir  out  1  0 = ascending, 1 = descending.
- pe_line_itr  out  kPartitionSizeLength  current line iteration.
- pe_scan_itr  out  kScanLength  current scan position.
- pe_line_kick  out  1  one-cycle pulse at start of each line.
- pe_en  out  1  PE advance enable.

Behaviour:
- Reset (async, reset_n=0): state IDLE; tt_ready=1; tt_done=0, tt_err=0, pe_en=0, pe_line_kick=0; all iterators, angle, mode and dir =0. Reset mid-angle aborts immediately, with no tt_done.
- All outputs registered; FSM states: IDLE, SETUP, LINE_START, SCAN, LINE_END, DONE.
- IDLE: tt_ready=1.
  - On tt_kick=1 with tt_angle<180: latch angle, go SETUP.
  - On tt_kick=1 with tt_angle>=180: tt_err=1 next cycle, stay IDLE.
- SETUP (1 cycle): tt_ready=0.
  - pe_scan_mode=0 if angle<45 or angle>=135, else 1.
  - pe_scan_dir=0 if angle<90, else 1.
  - pe_line_itr=0. Go LINE_START.
- LINE_START (1 cycle): pe_scan_itr = 0 if dir=0, else scan_max; pe_line_kick=1. Go SCAN.
- SCAN: pe_en = pv_valid, combinationally gated into the registered path so pe_en and pe_scan_itr refer to the same cycle.
  - pe_en=0: hold pe_scan_itr.
  - pe_en=1 and pe_scan_itr at end (scan_max if dir=0, 0 if dir=1): go LINE_END.
  - pe_en=1 otherwise: step ±1.
  - Both endpoints are inclusive: exactly kImageSize pe_en pulses per line.
- LINE_END (1 cycle): if pe_line_itr==kPartitionSize-1 go DONE, else increment pe_line_itr and go LINE_START.
- DONE (1 cycle): tt_done=1, go IDLE. tt_ready=1 from the following cycle.
- Kick while busy: ignored, no error.
- Latency without stalls: kick sampled at edge 0, tt_done high during cycle 2+kPartitionSize*(kImageSize+2). Defaults give cycle 42.
- Each stalled SCAN cycle adds exactly one cycle.
- pe_angle, pe_scan_mode and pe_scan_dir stay stable from SETUP until the next accepted kick.

Decomposition:
- Shared package nabp_scan_pkg holds:
  - state encoding;
  - scan_mode values (x=0, y=1) and scan_dir values;
  - angle constants kAngle45=45, kAngle90=90, kAngle135=135, kAngle180=180.
- One sub-module, nabp_scan_counter: loadable up/down counter with enable and terminal-count output. Instantiated for the scan iterator; the line iterator stays inline.

Test Plan:
- Angle 30, pv_valid=1 always:
  - mode=0, dir=0;
  - per line, pe_scan_itr runs 0..7 with 8 pe_en pulses;
  - pe_line_itr runs 0..3;
  - tt_done in cycle 42; tt_ready returns in cycle 43.
- Angle 100: mode=1, dir=1; pe_scan_itr runs 7..0 each line; 4 pe_line_kick pulses; 32 total pe_en.
- Angle 135 and angle 44: both give mode=0. Angle 45 and angle 90 give mode=1; angle 90 also gives dir=1.
- Angle 60 with pv_valid low for 3 cycles mid-line-1: scan_itr holds during the gap; tt_done in cycle 45; pe_en count still 32.
- Angle 200 kicked: tt_err pulses once, tt_ready stays 1, no pe_en. Second kick during a busy angle-10 run is ignored and completion is unchanged.
- reset_n low in cycle 20 of a run: all outputs return to reset values asynchronously, no tt_done. A kick with angle 0 after release completes normally in 42 cycles.

Source files
------------

// File: rtl/nabp_scan_pkg.sv
// Shared constants for the NABP processing scan controller: state encoding,
// scan mode/direction values and the angle thresholds that select them.
package nabp_scan_pkg;

    localparam int kAngleLength         = 9;
    localparam int kImageSize           = 8;
    localparam int kPartitionSize       = 4;
    localparam int kPartitionSizeLength = 3;
    localparam int kScanLength          = 4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_LINE_START = 3'd2;
    localparam logic [2:0] ST_SCAN       = 3'd3;
    localparam logic [2:0] ST_LINE_END   = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    localparam logic SCAN_MODE_X   = 1'b0;
    localparam logic SCAN_MODE_Y   = 1'b1;
    localparam logic SCAN_DIR_UP   = 1'b0;
    localparam logic SCAN_DIR_DOWN = 1'b1;

    localparam int unsigned kAngle45  = 32'd45;
    localparam int unsigned kAngle90  = 32'd90;
    localparam int unsigned kAngle135 = 32'd135;
    localparam int unsigned kAngle180 = 32'd180;

endpackage

// File: rtl/nabp_scan_counter.sv
// Loadable up/down counter; tc flags the endpoint in the current direction
// (MAX when counting up, zero when counting down).
module nabp_scan_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);

    logic [WIDTH-1:0] count_r;

    // Count register: load takes priority over stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= ZERO_V;
        end else if (load) begin
            count_r <= load_value;
        end else if (en) begin
            count_r <= dir ? (count_r - ONE_V) : (count_r + ONE_V);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = dir ? (count_r == ZERO_V) : (count_r == MAX_V);

endmodule

// File: rtl/nabp_processing_scan_control.sv
// Per-angle sequencer: walks every line of a partition and steps the scan
// iterator across each line, gating PE updates with the filtered-RAM valid.
module nabp_processing_scan_control
    import nabp_scan_pkg::*;
#(
    parameter int kAngleLength         = nabp_scan_pkg::kAngleLength,
    parameter int kImageSize           = nabp_scan_pkg::kImageSize,
    parameter int kPartitionSize       = nabp_scan_pkg::kPartitionSize,
    parameter int kPartitionSizeLength = nabp_scan_pkg::kPartitionSizeLength,
    parameter int kScanLength          = nabp_scan_pkg::kScanLength
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [kAngleLength-1:0]         tt_angle,
    input  logic                            tt_kick,
    output logic                            tt_ready,
    output logic                            tt_done,
    output logic                            tt_err,
    input  logic                            pv_valid,
    output logic [kAngleLength-1:0]         pe_angle,
    output logic                            pe_scan_mode,
    output logic                            pe_scan_dir,
    output logic [kPartitionSizeLength-1:0] pe_line_itr,
    output logic [kScanLength-1:0]          pe_scan_itr,
    output logic                            pe_line_kick,
    output logic                            pe_en
);

    localparam logic [kScanLength-1:0]          SCAN_MAX  = kScanLength'(kImageSize - 1);
    localparam logic [kScanLength-1:0]          SCAN_ZERO = kScanLength'(0);
    localparam logic [kPartitionSizeLength-1:0] LINE_LAST = kPartitionSizeLength'(kPartitionSize - 1);
    localparam logic [kPartitionSizeLength-1:0] LINE_ZERO = kPartitionSizeLength'(0);
    localparam logic [kPartitionSizeLength-1:0] LINE_ONE  = kPartitionSizeLength'(1);
    localparam logic [kAngleLength-1:0]         A45       = kAngleLength'(kAngle45);
    localparam logic [kAngleLength-1:0]         A90       = kAngleLength'(kAngle90);
    localparam logic [kAngleLength-1:0]         A135      = kAngleLength'(kAngle135);
    localparam logic [kAngleLength-1:0]         A180      = kAngleLength'(kAngle180);

    logic [2:0]                      state_r, state_s;
    logic [kAngleLength-1:0]         angle_r;
    logic                            mode_r, dir_r;
    logic [kPartitionSizeLength-1:0] line_itr_r;
    logic                            ready_r, done_r, err_r, line_kick_r, en_r;
    logic                            angle_ok_s, accept_s, mode_s, dir_s;
    logic                            cnt_load_s, cnt_en_s, scan_tc_s;
    logic [kScanLength-1:0]          cnt_load_value_s;

    assign angle_ok_s       = (tt_angle < A180);
    assign accept_s         = (state_r == ST_IDLE) && tt_kick && angle_ok_s;
    assign mode_s           = ((tt_angle < A45) || (tt_angle >= A135)) ? SCAN_MODE_X : SCAN_MODE_Y;
    assign dir_s            = (tt_angle < A90) ? SCAN_DIR_UP : SCAN_DIR_DOWN;
    // Loading on entry to LINE_START makes the start position visible during that cycle.
    assign cnt_load_s       = (state_s == ST_LINE_START);
    assign cnt_load_value_s = (dir_r == SCAN_DIR_DOWN) ? SCAN_MAX : SCAN_ZERO;
    assign cnt_en_s         = (state_r == ST_SCAN) && en_r && !scan_tc_s;

    // Next-state logic; SCAN advances only on cycles whose registered pe_en is high.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:       if (accept_s) state_s = ST_SETUP; else state_s = ST_IDLE;
            ST_SETUP:      state_s = ST_LINE_START;
            ST_LINE_START: state_s = ST_SCAN;
            ST_SCAN:       if (en_r && scan_tc_s) state_s = ST_LINE_END; else state_s = ST_SCAN;
            ST_LINE_END:   if (line_itr_r == LINE_LAST) state_s = ST_DONE; else state_s = ST_LINE_START;
            ST_DONE:       state_s = ST_IDLE;
            default:       state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            angle_r     <= {kAngleLength{1'b0}};
            mode_r      <= SCAN_MODE_X;
            dir_r       <= SCAN_DIR_UP;
            line_itr_r  <= LINE_ZERO;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            line_kick_r <= 1'b0;
            en_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == ST_IDLE);
            done_r      <= (state_s == ST_DONE);
            err_r       <= (state_r == ST_IDLE) && tt_kick && !angle_ok_s;
            line_kick_r <= (state_s == ST_LINE_START);
            en_r        <= (state_s == ST_SCAN) && pv_valid;
            if (accept_s) begin
                angle_r <= tt_angle;
                mode_r  <= mode_s;
                dir_r   <= dir_s;
            end else begin
                angle_r <= angle_r;
                mode_r  <= mode_r;
                dir_r   <= dir_r;
            end
            if (state_s == ST_SETUP) begin
                line_itr_r <= LINE_ZERO;
            end else if ((state_r == ST_LINE_END) && (state_s == ST_LINE_START)) begin
                line_itr_r <= line_itr_r + LINE_ONE;
            end else begin
                line_itr_r <= line_itr_r;
            end
        end
    end

    nabp_scan_counter #(
        .WIDTH (kScanLength),
        .MAX   (kImageSize - 1)
    ) u_scan_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load_s),
        .load_value (cnt_load_value_s),
        .en         (cnt_en_s),
        .dir        (dir_r),
        .count      (pe_scan_itr),
        .tc         (scan_tc_s)
    );

    assign tt_ready     = ready_r;
    assign tt_done      = done_r;
    assign tt_err       = err_r;
    assign pe_angle     = angle_r;
    assign pe_scan_mode = mode_r;
    assign pe_scan_dir  = dir_r;
    assign pe_line_itr  = line_itr_r;
    assign pe_line_kick = line_kick_r;
    assign pe_en        = en_r;

endmodule

// File: tb/tb_nabp_processing_scan_control.sv
// Directed bench for the scan controller; cycle k is the interval after
// clock edge k-1, with the kick sampled at edge 0.
module tb_nabp_processing_scan_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] tt_angle;
    logic       tt_kick;
    logic       tt_ready, tt_done, tt_err;
    logic       pv_valid;
    logic [8:0] pe_angle;
    logic       pe_scan_mode, pe_scan_dir;
    logic [2:0] pe_line_itr;
    logic [3:0] pe_scan_itr;
    logic       pe_line_kick, pe_en;

    int total = 0;
    int bad   = 0;

    nabp_processing_scan_control dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tt_angle     (tt_angle),
        .tt_kick      (tt_kick),
        .tt_ready     (tt_ready),
        .tt_done      (tt_done),
        .tt_err       (tt_err),
        .pv_valid     (pv_valid),
        .pe_angle     (pe_angle),
        .pe_scan_mode (pe_scan_mode),
        .pe_scan_dir  (pe_scan_dir),
        .pe_line_itr  (pe_line_itr),
        .pe_scan_itr  (pe_scan_itr),
        .pe_line_kick (pe_line_kick),
        .pe_en        (pe_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, tt_ready, 1);
        check({tag, "_done"}, tt_done, 0);
        check({tag, "_err"}, tt_err, 0);
        check({tag, "_en"}, pe_en, 0);
        check({tag, "_lkick"}, pe_line_kick, 0);
        check({tag, "_line"}, pe_line_itr, 0);
        check({tag, "_scan"}, pe_scan_itr, 0);
        check({tag, "_angle"}, pe_angle, 0);
        check({tag, "_mode"}, pe_scan_mode, 0);
        check({tag, "_dir"}, pe_scan_dir, 0);
    endtask

    // Kick one angle and monitor it until tt_ready returns (bounded at 100 cycles).
    task automatic run_angle(input logic [8:0] a, input bit do_stall, input bit busy_kick,
                             input int rst_at,
                             output int done_cyc, output int ready_cyc, output int en_cnt,
                             output int lk_cnt, output int err_cnt,
                             output logic mode, output logic dir);
        int exp_itr;
        int stall_cyc;
        done_cyc = -1; ready_cyc = -1; en_cnt = 0; lk_cnt = 0; err_cnt = 0;
        exp_itr = 0; stall_cyc = -1; mode = 1'b0; dir = 1'b0;
        @(negedge clk);
        tt_angle = a;
        tt_kick  = 1'b1;
        pv_valid = 1'b1;
        @(posedge clk);
        #1 tt_kick = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (cyc == rst_at) begin
                reset_n = 1'b0;
                #1 check_reset_values("mid_rst");
                return;
            end
            if (cyc == 1) begin
                mode = pe_scan_mode;
                dir  = pe_scan_dir;
                check("busy_ready", tt_ready, 0);
                check("latched_angle", pe_angle, a);
            end
            if (pe_line_kick) begin
                check("line_itr", pe_line_itr, lk_cnt);
                exp_itr = dir ? 7 : 0;
                check("scan_start", pe_scan_itr, exp_itr);
                lk_cnt++;
            end
            if (stall_cyc > 0 && cyc > stall_cyc && cyc <= stall_cyc + 3) begin
                check("stall_en", pe_en, 0);
                check("stall_hold", pe_scan_itr, exp_itr);
            end
            if (pe_en) begin
                check("scan_itr", pe_scan_itr, exp_itr);
                exp_itr = dir ? exp_itr - 1 : exp_itr + 1;
                en_cnt++;
            end
            if (tt_err) err_cnt++;
            if (tt_done && done_cyc < 0) done_cyc = cyc;
            if (done_cyc > 0 && tt_ready && ready_cyc < 0) ready_cyc = cyc;
            if (do_stall && stall_cyc < 0 && pe_en && pe_line_itr == 3'd1 && pe_scan_itr == 4'd3)
                stall_cyc = cyc;
            pv_valid = !(stall_cyc > 0 && cyc >= stall_cyc && cyc < stall_cyc + 3);
            if (busy_kick) begin
                tt_kick  = (cyc == 10);
                tt_angle = (cyc == 10) ? 9'd50 : a;
            end
            if (ready_cyc > 0) break;
        end
        pv_valid = 1'b1;
        tt_kick  = 1'b0;
    endtask

    int   d, r, e, k, er, n;
    logic m, di;

    initial begin
        reset_n  = 1'b0;
        tt_angle = 9'd0;
        tt_kick  = 1'b0;
        pv_valid = 1'b1;
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Angle 30: x-scan ascending, no stalls.
        run_angle(9'd30, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a30_mode", m, 0);
        check("a30_dir", di, 0);
        check("a30_done", d, 42);
        check("a30_ready", r, 43);
        check("a30_en", e, 32);
        check("a30_lkick", k, 4);

        // Angle 100: y-scan descending.
        run_angle(9'd100, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a100_mode", m, 1);
        check("a100_dir", di, 1);
        check("a100_done", d, 42);
        check("a100_en", e, 32);
        check("a100_lkick", k, 4);

        // Mode/direction boundaries.
        run_angle(9'd135, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a135_mode", m, 0);
        check("a135_dir", di, 1);
        run_angle(9'd44, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a44_mode", m, 0);
        check("a44_dir", di, 0);
        run_angle(9'd45, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a45_mode", m, 1);
        check("a45_dir", di, 0);
        run_angle(9'd90, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a90_mode", m, 1);
        check("a90_dir", di, 1);
        run_angle(9'd89, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a89_dir", di, 0);

        // Angle 60 with a three-cycle stall in line 1.
        run_angle(9'd60, 1'b1, 1'b0, 0, d, r, e, k, er, m, di);
        check("a60_done", d, 45);
        check("a60_en", e, 32);

        // Illegal angle 200: one error pulse, stays idle.
        @(negedge clk);
        tt_angle = 9'd200;
        tt_kick  = 1'b1;
        @(posedge clk);
        #1 tt_kick = 1'b0;
        er = 0; e = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (tt_err) er++;
            if (pe_en) e++;
            check("a200_ready", tt_ready, 1);
        end
        check("a200_err", er, 1);
        check("a200_en", e, 0);

        // Angle 179 is the last legal angle.
        run_angle(9'd179, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a179_done", d, 42);
        check("a179_err", er, 0);

        // Angle 10 with a second kick while busy.
        run_angle(9'd10, 1'b0, 1'b1, 0, d, r, e, k, er, m, di);
        check("busy_done", d, 42);
        check("busy_err", er, 0);
        check("busy_en", e, 32);
        check("busy_angle", pe_angle, 10);

        // Reset in cycle 20 aborts without tt_done.
        run_angle(9'd30, 1'b0, 1'b0, 20, d, r, e, k, er, m, di);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tt_done) n++;
        end
        check("rst_no_done", n, 0);
        check("rst_ready", tt_ready, 1);

        // Angle 0 after reset completes normally.
        run_angle(9'd0, 1'b0, 1'b0, 0, d, r, e, k, er, m, di);
        check("a0_done", d, 42);
        check("a0_en", e, 32);
        check("a0_mode", m, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
